// File: rtl/task_scheduler.sv
// task_scheduler: tags host boards with sequential ids, issues them to the solver and collects per-id results
module task_scheduler #(
    parameter int MAX_TASKS = 1024,
    localparam int AW = (MAX_TASKS > 1) ? $clog2(MAX_TASKS) : 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic [127:0]  i_load_data,
    input  logic          i_load_last,
    input  logic          i_load_valid,
    output logic          o_load_ready,
    output logic [143:0]  o_task_data,
    output logic          o_task_valid,
    input  logic          i_task_ready,
    input  logic [39:0]   i_result_data,
    input  logic          i_result_valid,
    output logic          o_result_ready,
    input  logic [AW-1:0] i_rd_addr,
    output logic [8:0]    o_rd_data,
    output logic [15:0]   o_issued,
    output logic [15:0]   o_solved,
    output logic [31:0]   o_nodes_sum,
    output logic          o_done,
    output logic          o_err_dup,
    output logic          o_err_range
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t         r_state, w_next;
    logic           r_live;
    logic           r_task_valid;
    logic [143:0]   r_task_data;
    logic [15:0]    r_issued, r_solved;
    logic [31:0]    r_nodes;
    logic           r_err_dup, r_err_range;
    logic [MAX_TASKS-1:0] r_vld;
    logic [7:0]     r_res_mem [MAX_TASKS];
    logic [8:0]     r_rd_data;

    logic           w_room, w_load_fire, w_task_fire, w_res_beat, w_live_id, w_in_range;
    logic           w_range_bad, w_dup, w_write, w_rd_ok;
    logic [15:0]    w_res_id, w_nodes;
    logic [7:0]     w_res;
    logic [AW-1:0]  w_idx;

    assign w_res       = i_result_data[39:32];
    assign w_res_id    = i_result_data[31:16];
    assign w_nodes     = i_result_data[15:0];
    assign w_idx       = w_res_id[AW-1:0];
    assign w_room      = r_issued < 16'(MAX_TASKS);
    assign w_load_fire = i_load_valid && o_load_ready;
    assign w_task_fire = r_task_valid && i_task_ready;
    // A result beat coinciding with clear belongs to the old batch and is dropped
    assign w_res_beat  = r_live && i_result_valid && !i_clear;
    assign w_live_id   = w_res_beat && w_res_id != 16'hFFFF;
    assign w_in_range  = w_res_id < r_issued;
    assign w_range_bad = w_live_id && !w_in_range;
    assign w_dup       = w_live_id && w_in_range && r_vld[w_idx];
    assign w_write     = w_live_id && w_in_range && !r_vld[w_idx];
    assign w_rd_ok     = 32'(i_rd_addr) < MAX_TASKS;

    assign o_task_data    = r_task_data;
    assign o_task_valid   = r_task_valid;
    assign o_result_ready = r_live;
    assign o_rd_data      = r_rd_data;
    assign o_issued       = r_issued;
    assign o_solved       = r_solved;
    assign o_nodes_sum    = r_nodes;
    assign o_err_dup      = r_err_dup;
    assign o_err_range    = r_err_range;

    // Batch state register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // Batch progression; saturating the id space closes the batch as if load_last had arrived
    always_comb begin
        w_next = i_clear ? S_IDLE :
                 (r_state == S_IDLE || r_state == S_LOAD) ?
                     ((w_load_fire && i_load_last) ? S_DRAIN : w_load_fire ? S_LOAD : !w_room ? S_DRAIN : r_state) :
                 (r_state == S_DRAIN && r_solved == r_issued && !r_task_valid) ? S_DONE : r_state;
    end

    // Host-side readiness and completion flag
    always_comb begin
        o_load_ready = r_live && !i_clear && (r_state == S_IDLE || r_state == S_LOAD) &&
                       (!r_task_valid || i_task_ready) && w_room;
        o_done = r_state == S_DONE;
    end

    // Handshakes stay closed until the first clock after reset release
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_live <= 1'b0;
        else r_live <= 1'b1;
    end

    // Single-stage issue register: load tags the board with the next id
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_task_valid <= 1'b0;
            r_task_data  <= '0;
            r_issued     <= '0;
        end else if (i_clear) begin
            r_task_valid <= 1'b0;
            r_issued     <= '0;
        end else if (w_load_fire) begin
            r_task_data  <= {i_load_data, r_issued};
            r_task_valid <= 1'b1;
            r_issued     <= r_issued + 16'd1;
        end else if (w_task_fire) begin
            r_task_valid <= 1'b0;
        end
    end

    // Result accounting and sticky error flags
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_solved    <= '0;
            r_nodes     <= '0;
            r_err_dup   <= 1'b0;
            r_err_range <= 1'b0;
        end else if (i_clear) begin
            r_solved    <= '0;
            r_nodes     <= '0;
            r_err_dup   <= 1'b0;
            r_err_range <= 1'b0;
        end else begin
            if (w_range_bad) r_err_range <= 1'b1;
            if (w_dup) r_err_dup <= 1'b1;
            if (w_write) begin
                r_solved <= r_solved + 16'd1;
                r_nodes  <= r_nodes + {16'd0, w_nodes};
            end
        end
    end

    // Per-entry valid bits let clear empty the table in one cycle
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_vld <= '0;
        else if (i_clear) r_vld <= '0;
        else if (w_write) r_vld[w_idx] <= 1'b1;
    end

    // Result storage; contents are only meaningful behind a set valid bit
    always_ff @(posedge i_clock) begin
        if (w_write) r_res_mem[w_idx] <= w_res;
    end

    // Registered table read; invalid entries read as zero
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_rd_data <= '0;
        else r_rd_data <= (w_rd_ok && r_vld[i_rd_addr]) ? {1'b1, r_res_mem[i_rd_addr]} : 9'h000;
    end
endmodule
